// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the memory-wait FSM encoding, the control bundle and small decode helpers.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MD_LAT_DEFAULT = 32;
  localparam int CNT_W_DEFAULT  = 6;
  localparam int PERF_W_DEFAULT = 16;

  // One bit per pipeline control line, in the order they leave the top.
  typedef struct packed {
    logic pc_write;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
  } ctrl_t;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md.sv
// Mul/div occupancy tracker: countdown from MD_LAT-1, busy flag and a
// single-cycle done pulse when the unit frees up.
module md_occupancy_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  output logic md_busy,
  output logic md_done
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MD_LAT - 1);

  logic [CNT_W-1:0] md_cnt_reg;
  logic [CNT_W-1:0] md_cnt_next;
  logic             md_busy_reg;
  logic             md_busy_next;
  logic             md_done_reg;
  logic             md_done_next;

  // A start while busy is dropped; the running operation is never reloaded.
  always_comb begin
    md_cnt_next  = md_cnt_reg;
    md_busy_next = md_busy_reg;
    md_done_next = 1'b0;
    if (md_busy_reg) begin
      if (md_cnt_reg == '0) begin
        md_busy_next = 1'b0;
        md_done_next = 1'b1;
      end else begin
        md_cnt_next = md_cnt_reg - 1'b1;
      end
    end else if (md_start) begin
      md_cnt_next  = RELOAD;
      md_busy_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_cnt_reg  <= '0;
      md_busy_reg <= 1'b0;
      md_done_reg <= 1'b0;
    end else begin
      md_cnt_reg  <= md_cnt_next;
      md_busy_reg <= md_busy_next;
      md_done_reg <= md_done_next;
    end
  end

  assign md_busy = md_busy_reg;
  assign md_done = md_done_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: prioritised same-cycle
// hazard decode, data-memory wait tracking, mul/div occupancy and stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int PERF_W = PERF_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              id_jump,
  input  logic              id_md_use,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rt,
  input  logic              ex_branch_taken,
  input  logic              ex_md_start,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  input  logic              imem_ready,
  output logic              pc_write,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              idex_flush,
  output logic              exmem_stall,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_cycles
);

  mem_state_t        state_reg;
  mem_state_t        state_next;
  ctrl_t             ctrl;
  logic              freeze;
  logic              md_hazard;
  logic              load_use;
  logic [PERF_W-1:0] stall_cycles_reg;
  logic [PERF_W-1:0] stall_cycles_next;

  assign freeze    = dmem_req & ~dmem_ready;
  assign md_hazard = md_busy & id_md_use;
  assign load_use  = ex_memread &
                     (reg_match(ex_rt, id_rs) | (id_uses_rt & reg_match(ex_rt, id_rt)));

  // The unit keeps counting through a freeze, but a new issue is only taken
  // when EX is actually advancing.
  md_occupancy_cnt #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md (
    .clk      (clk),
    .rst      (rst),
    .md_start (ex_md_start & ~freeze),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (freeze) state_next = MEM_WAIT;
      MEM_WAIT: if (dmem_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // First match wins. A freeze holds EX, so a pending branch is simply
  // re-presented once memory completes; a branch discards the ID instruction.
  always_comb begin
    ctrl          = '0;
    ctrl.pc_write = 1'b1;
    if (!rst) begin
      ctrl = '0;
    end else if (freeze) begin
      ctrl.pc_write    = 1'b0;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_stall  = 1'b1;
      ctrl.exmem_stall = 1'b1;
    end else if (ex_branch_taken) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (md_hazard || load_use) begin
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_stall = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (id_jump) begin
      ctrl.ifid_flush = 1'b1;
    end else if (!imem_ready) begin
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_flush = 1'b1;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_stall  = ctrl.ifid_stall;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_stall  = ctrl.idex_stall;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_stall = ctrl.exmem_stall;

  always_comb begin
    stall_cycles_next = stall_cycles_reg;
    if (!ctrl.pc_write && (stall_cycles_reg != '1)) begin
      stall_cycles_next = stall_cycles_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_reg <= '0;
    end else begin
      stall_cycles_reg <= stall_cycles_next;
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MD_LAT = 32;
  localparam int CNT_W  = 6;
  localparam int PERF_W = 16;
  localparam int PMAX   = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 0, id_jump = 0, id_md_use = 0, ex_memread = 0;
  logic        ex_branch_taken = 0, ex_md_start = 0, dmem_req = 0;
  logic        dmem_ready = 1, imem_ready = 1;
  logic        pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;
  logic        md_busy, md_done;
  logic [PERF_W-1:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: remaining busy cycles of the mul/div, done flag, stall count.
  int   m_left  = 0;
  logic m_done  = 0;
  int   m_stall = 0;
  logic [5:0] exp_ctrl;
  logic [5:0] got;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .id_md_use(id_md_use), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_write(pc_write), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
    .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
  );

  assign got = {pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall};

  // Expected control word {pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}
  function automatic logic [5:0] ref_ctrl(
    input logic rn, input logic busy, input logic dreq, input logic drdy,
    input logic br, input logic mduse, input logic mrd, input logic [4:0] ert,
    input logic [4:0] rs, input logic [4:0] rt, input logic urt,
    input logic jmp, input logic irdy);
    logic lu;
    lu = mrd && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
    if (!rn)               return 6'b000000;
    if (dreq && !drdy)     return 6'b010101;
    if (br)                return 6'b101010;
    if (busy && mduse)     return 6'b010010;
    if (lu)                return 6'b010010;
    if (jmp)               return 6'b101000;
    if (!irdy)             return 6'b001000;
    return 6'b100000;
  endfunction

  always_comb begin
    exp_ctrl = ref_ctrl(rst, (m_left > 0), dmem_req, dmem_ready, ex_branch_taken,
                        id_md_use, ex_memread, ex_rt, id_rs, id_rt, id_uses_rt,
                        id_jump, imem_ready);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_stall <= 0;
    end else begin
      if (!exp_ctrl[5] && m_stall < PMAX) m_stall <= m_stall + 1;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        m_done <= (m_left == 1);
      end else begin
        m_done <= 1'b0;
        if (ex_md_start && !(dmem_req && !dmem_ready)) m_left <= MD_LAT;
      end
    end
  end

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; id_jump = 0; id_md_use = 0;
    ex_memread = 0; ex_branch_taken = 0; ex_md_start = 0; dmem_req = 0;
    dmem_ready = 1; imem_ready = 1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    dmem_req = 1; dmem_ready = 0; ex_branch_taken = 1;
    to_neg();
    n_cmp++;
    if (got !== 6'b000000) begin n_err++; $display("FAIL reset_ctrl got=%b exp=000000", got); end
    n_cmp++;
    if (md_busy !== 1'b0 || md_done !== 1'b0) begin
      n_err++; $display("FAIL reset_md busy=%b done=%b exp=0/0", md_busy, md_done);
    end
    n_cmp++;
    if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
    to_drive();
    rst = 1'b1;
    idle_inputs();
    to_neg();
    n_cmp++;
    if (got !== 6'b100000) begin n_err++; $display("FAIL reset_release got=%b exp=100000", got); end
    $display("reset: ctrl=%b busy=%b stall=%0d", got, md_busy, stall_cycles);
    to_drive();
  endtask

  task automatic test_load_use();
    logic [4:0] ert_t[4] = '{5'd8, 5'd0, 5'd8, 5'd8};
    logic [4:0] rs_t[4]  = '{5'd8, 5'd0, 5'd3, 5'd3};
    logic [4:0] rt_t[4]  = '{5'd1, 5'd0, 5'd8, 5'd8};
    logic       urt_t[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [5:0] exp_t[4] = '{6'b010010, 6'b100000, 6'b010010, 6'b100000};
    for (int i = 0; i < 4; i++) begin
      ex_memread = 1; ex_rt = ert_t[i]; id_rs = rs_t[i]; id_rt = rt_t[i]; id_uses_rt = urt_t[i];
      to_neg();
      n_cmp++;
      if (got !== exp_t[i]) begin n_err++; $display("FAIL load_use_%0d got=%b exp=%b", i, got, exp_t[i]); end
      $display("load_use %0d: ex_rt=%0d rs=%0d rt=%0d ctrl=%b", i, ert_t[i], rs_t[i], rt_t[i], got);
      to_drive();
      idle_inputs();
      to_neg();
      n_cmp++;
      if (got !== 6'b100000) begin n_err++; $display("FAIL load_use_after_%0d got=%b exp=100000", i, got); end
      n_cmp++;
      if (stall_cycles !== m_stall[PERF_W-1:0]) begin
        n_err++; $display("FAIL load_use_stall_%0d got=%0d exp=%0d", i, stall_cycles, m_stall);
      end
      to_drive();
    end
  endtask

  task automatic test_branch_vs_load();
    ex_memread = 1; ex_rt = 8; id_rs = 8; ex_branch_taken = 1; id_jump = 1;
    to_neg();
    n_cmp++;
    if (got !== 6'b101010) begin n_err++; $display("FAIL branch_vs_load got=%b exp=101010", got); end
    $display("branch_vs_load: ctrl=%b", got);
    to_drive();
    idle_inputs();
    id_jump = 1;
    to_neg();
    n_cmp++;
    if (got !== 6'b101000) begin n_err++; $display("FAIL jump got=%b exp=101000", got); end
    to_drive();
    idle_inputs();
    imem_ready = 0;
    to_neg();
    n_cmp++;
    if (got !== 6'b001000) begin n_err++; $display("FAIL imem_wait got=%b exp=001000", got); end
    to_drive();
    idle_inputs();
  endtask

  task automatic test_muldiv();
    int bad;
    rst = 1'b0;
    to_drive();
    rst = 1'b1;
    idle_inputs();
    ex_md_start = 1;
    to_neg();
    n_cmp++;
    if (md_busy !== 1'b0 || got !== 6'b100000) begin
      n_err++; $display("FAIL md_issue busy=%b ctrl=%b exp=0/100000", md_busy, got);
    end
    to_drive();
    ex_md_start = 0; id_md_use = 1;
    bad = 0;
    for (int i = 0; i < MD_LAT; i++) begin
      to_neg();
      if (md_busy !== 1'b1 || md_done !== 1'b0 || got !== 6'b010010) begin
        bad++;
        $display("FAIL md_busy_cyc%0d busy=%b done=%b ctrl=%b exp=1/0/010010", i, md_busy, md_done, got);
      end
      to_drive();
    end
    n_cmp++;
    if (bad != 0) n_err++;
    to_neg();
    n_cmp++;
    if (md_busy !== 1'b0 || md_done !== 1'b1 || got !== 6'b100000) begin
      n_err++; $display("FAIL md_finish busy=%b done=%b ctrl=%b exp=0/1/100000", md_busy, md_done, got);
    end
    n_cmp++;
    if (stall_cycles !== 16'd32) begin n_err++; $display("FAIL md_stall_count got=%0d exp=32", stall_cycles); end
    $display("muldiv: busy_cycles=%0d stall=%0d", MD_LAT, stall_cycles);
    to_drive();
    to_neg();
    n_cmp++;
    if (md_done !== 1'b0) begin n_err++; $display("FAIL md_done_width got=%b exp=0", md_done); end
    to_drive();
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    dmem_req = 1; dmem_ready = 0; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      n_cmp++;
      if (got !== 6'b010101) begin n_err++; $display("FAIL mem_wait_%0d got=%b exp=010101", i, got); end
      if (i > 0) begin
        n_cmp++;
        if (dut.state_reg !== MEM_WAIT) begin
          n_err++; $display("FAIL mem_state_%0d got=%0d exp=MEM_WAIT", i, dut.state_reg);
        end
      end
      $display("mem_wait %0d: ctrl=%b", i, got);
      to_drive();
    end
    dmem_ready = 1;
    to_neg();
    n_cmp++;
    if (got !== 6'b101010) begin n_err++; $display("FAIL mem_ready_branch got=%b exp=101010", got); end
    to_drive();
    idle_inputs();
    to_neg();
    n_cmp++;
    if (dut.state_reg !== IDLE) begin n_err++; $display("FAIL mem_state_idle got=%0d exp=IDLE", dut.state_reg); end
    to_drive();
  endtask

  task automatic test_reset_mid_md();
    int bad;
    idle_inputs();
    ex_md_start = 1;
    to_drive();
    ex_md_start = 0;
    for (int i = 0; i < 21; i++) to_drive();
    n_cmp++;
    if (dut.u_md.md_cnt_reg !== 6'd10) begin
      n_err++; $display("FAIL md_cnt_before_reset got=%0d exp=10", dut.u_md.md_cnt_reg);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (md_busy !== 1'b0 || stall_cycles !== 16'd0 || got !== 6'b000000) begin
      n_err++; $display("FAIL reset_mid_md busy=%b stall=%0d ctrl=%b exp=0/0/000000", md_busy, stall_cycles, got);
    end
    to_drive();
    to_drive();
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      to_neg();
      if (md_done !== 1'b0 || md_busy !== 1'b0) begin
        bad++; $display("FAIL md_after_reset_%0d done=%b busy=%b exp=0/0", i, md_done, md_busy);
      end
      to_drive();
    end
    n_cmp++;
    if (bad != 0) n_err++;
    $display("reset_mid_md: busy=%b stall=%0d", md_busy, stall_cycles);
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      dmem_req        = ($urandom % 4) == 0;
      dmem_ready      = ($urandom % 3) != 0;
      ex_branch_taken = ($urandom % 8) == 0;
      ex_md_start     = ($urandom % 6) == 0;
      id_md_use       = ($urandom % 3) == 0;
      ex_memread      = ($urandom % 3) == 0;
      ex_rt           = 5'($urandom % 6);
      id_rs           = 5'($urandom % 6);
      id_rt           = 5'($urandom % 6);
      id_uses_rt      = $urandom % 2;
      id_jump         = ($urandom % 8) == 0;
      imem_ready      = ($urandom % 5) != 0;
      to_neg();
      n_cmp++;
      if (got !== exp_ctrl) begin n_err++; $display("FAIL rand_ctrl cyc%0d got=%b exp=%b", c, got, exp_ctrl); end
      n_cmp++;
      if (md_busy !== (m_left > 0) || md_done !== m_done) begin
        n_err++; $display("FAIL rand_md cyc%0d busy=%b done=%b exp=%b/%b", c, md_busy, md_done, (m_left > 0), m_done);
      end
      n_cmp++;
      if (stall_cycles !== m_stall[PERF_W-1:0]) begin
        n_err++; $display("FAIL rand_stall cyc%0d got=%0d exp=%0d", c, stall_cycles, m_stall);
      end
      $display("rand %0d: ctrl=%b busy=%b done=%b stall=%0d", c, got, md_busy, md_done, stall_cycles);
      to_drive();
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    idle_inputs();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 65536 + 5; i++) to_drive();
    to_neg();
    n_cmp++;
    if (stall_cycles !== 16'hFFFF || m_stall != PMAX) begin
      n_err++; $display("FAIL saturate got=%h exp=ffff", stall_cycles);
    end
    $display("saturation: stall=%h", stall_cycles);
    to_drive();
    idle_inputs();
    to_neg();
    to_drive();
    to_neg();
    n_cmp++;
    if (stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL saturate_hold got=%h exp=ffff", stall_cycles); end
    to_drive();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch_vs_load();
    test_muldiv();
    test_mem_wait();
    test_reset_mid_md();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
